smm_operand_loader: RTL and testbench

// - Upstream feeder for the 4x4 Strassen multiplier stage.
// - Accepts A/B element pairs as a valid/ready stream and assembles them row-major into the

---
 rtl/smm_pkg.sv | 19 +
 rtl/smm_operand_loader.sv | 156 +++++++++++++++
 tb/tb_smm_operand_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/smm_pkg.sv
// Shared constants, state encoding and element-offset helper for the
// Strassen-multiplier operand loader.
package smm_pkg;

   localparam int SMM_ELEMS = 16;
   localparam int SMM_IDX_W = 4;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } smm_state_e;

   // Bit offset of element idx inside a flattened row-major 4x4 bus.
   function automatic int unsigned elem_lsb(input logic [SMM_IDX_W-1:0] idx,
                                            input int unsigned          dw);
      elem_lsb = 32'(idx) * dw;
   endfunction

endpackage

// File: rtl/smm_operand_loader.sv
// Assembles a row-major stream of A/B element pairs into flattened 4x4 operand
// buses and issues spaced single-cycle load strobes to the Strassen multiplier.
module smm_operand_loader
   import smm_pkg::*;
#(
   parameter  int DATAWIDTH    = 32,
   parameter  int MIN_LOAD_GAP = 4,
   localparam int BUSWIDTH     = DATAWIDTH * SMM_ELEMS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a_elem,
   input  logic [DATAWIDTH-1:0] b_elem,
   input  logic                 sel_in,
   input  logic                 flush,
   output logic [BUSWIDTH-1:0]  A_out,
   output logic [BUSWIDTH-1:0]  B_out,
   output logic                 load_out,
   output logic                 sel_out,
   output logic                 busy
);

   localparam int GAP_W = (MIN_LOAD_GAP > 1) ? $clog2(MIN_LOAD_GAP) : 1;
   localparam logic [GAP_W-1:0]     GAP_RELOAD = GAP_W'(MIN_LOAD_GAP - 1);
   localparam logic [GAP_W-1:0]     GAP_ZERO   = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0]     GAP_ONE    = GAP_W'(1);
   localparam logic [SMM_IDX_W-1:0] IDX_ZERO   = {SMM_IDX_W{1'b0}};
   localparam logic [SMM_IDX_W-1:0] IDX_ONE    = SMM_IDX_W'(1);
   localparam logic [SMM_IDX_W-1:0] IDX_LAST   = SMM_IDX_W'(SMM_ELEMS - 1);

   smm_state_e           state_r;
   smm_state_e           state_nxt_s;
   logic [SMM_IDX_W-1:0] idx_r;
   logic [GAP_W-1:0]     gap_r;
   logic [BUSWIDTH-1:0]  a_asm_r;
   logic [BUSWIDTH-1:0]  b_asm_r;
   logic                 sel_asm_r;
   logic                 in_ready_s;
   logic                 issue_s;
   logic                 accept_s;

   assign accept_s = in_valid && in_ready_s && !flush;
   assign in_ready = in_ready_s;
   assign busy     = (state_r != ST_FILL) || (idx_r != IDX_ZERO) || (gap_r != GAP_ZERO);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FILL;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, ready and load-issue decision; flush overrides both a
   // completing beat and a pending issue.
   always_comb begin
      state_nxt_s = state_r;
      in_ready_s  = 1'b0;
      issue_s     = 1'b0;
      case (state_r)
         ST_FILL: begin
            in_ready_s = 1'b1;
            if (flush) begin
               state_nxt_s = ST_FILL;
            end else if (in_valid && (idx_r == IDX_LAST)) begin
               state_nxt_s = ST_FULL;
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_FULL: begin
            if (flush) begin
               state_nxt_s = ST_FILL;
            end else if (gap_r == GAP_ZERO) begin
               issue_s     = 1'b1;
               state_nxt_s = ST_FILL;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: begin
            state_nxt_s = ST_FILL;
         end
      endcase
   end

   // Beat index and load-spacing counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r <= IDX_ZERO;
         gap_r <= GAP_ZERO;
      end else begin
         if (flush) begin
            idx_r <= IDX_ZERO;
         end else if (accept_s) begin
            idx_r <= idx_r + IDX_ONE;
         end else begin
            idx_r <= idx_r;
         end
         if (issue_s) begin
            gap_r <= GAP_RELOAD;
         end else if (gap_r != GAP_ZERO) begin
            gap_r <= gap_r - GAP_ONE;
         end else begin
            gap_r <= GAP_ZERO;
         end
      end
   end

   // Assembly buffers; the mode bit belongs to the matrix and is taken from beat 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_asm_r   <= {BUSWIDTH{1'b0}};
         b_asm_r   <= {BUSWIDTH{1'b0}};
         sel_asm_r <= 1'b0;
      end else if (accept_s) begin
         a_asm_r[elem_lsb(idx_r, DATAWIDTH) +: DATAWIDTH] <= a_elem;
         b_asm_r[elem_lsb(idx_r, DATAWIDTH) +: DATAWIDTH] <= b_elem;
         if (idx_r == IDX_ZERO) begin
            sel_asm_r <= sel_in;
         end else begin
            sel_asm_r <= sel_asm_r;
         end
      end else begin
         a_asm_r   <= a_asm_r;
         b_asm_r   <= b_asm_r;
         sel_asm_r <= sel_asm_r;
      end
   end

   // Output stage: operands and mode only move on a load edge so the
   // multiplier sees them stable between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         A_out    <= {BUSWIDTH{1'b0}};
         B_out    <= {BUSWIDTH{1'b0}};
         sel_out  <= 1'b0;
         load_out <= 1'b0;
      end else begin
         load_out <= issue_s;
         if (issue_s) begin
            A_out   <= a_asm_r;
            B_out   <= b_asm_r;
            sel_out <= sel_asm_r;
         end else begin
            A_out   <= A_out;
            B_out   <= B_out;
            sel_out <= sel_out;
         end
      end
   end

endmodule

// File: tb/tb_smm_operand_loader.sv
// Self-checking bench for smm_operand_loader: directed scenarios plus random
// traffic, all compared each cycle against a cycle-number based reference model.
module tb_smm_operand_loader;

   localparam int DW  = 32;
   localparam int BW  = DW * 16;
   localparam int GAP = 24;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a_elem;
   logic [DW-1:0] b_elem;
   logic          sel_in;
   logic          flush;
   logic [BW-1:0] A_out;
   logic [BW-1:0] B_out;
   logic          load_out;
   logic          sel_out;
   logic          busy;

   int cyc     = 0;
   int n_check = 0;
   int n_pass  = 0;

   smm_operand_loader #(.DATAWIDTH(DW), .MIN_LOAD_GAP(GAP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_elem(a_elem), .b_elem(b_elem), .sel_in(sel_in), .flush(flush),
      .A_out(A_out), .B_out(B_out), .load_out(load_out), .sel_out(sel_out),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_check++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // The model counts beats into arrays, holds a completed matrix as "pending",
   // and issues it once enough cycles have elapsed since the previous load.
   logic [DW-1:0] ma[16], mb[16], pa[16], pb[16];
   logic          m_sel_asm, m_psel, m_pending, m_load, m_sel_out, m_valid;
   logic [BW-1:0] m_A, m_B;
   int            m_count, m_last;

   function automatic bit gap_clear(input int t, input int last);
      return (last < 0) || (t >= last + GAP - 1);
   endfunction

   initial begin
      m_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("ready",    {511'd0, in_ready}, {511'd0, !m_pending});
            check("busy",     {511'd0, busy},
                  {511'd0, (m_pending || m_count != 0 || !gap_clear(cyc, m_last))});
            check("load_out", {511'd0, load_out}, {511'd0, m_load});
            check("sel_out",  {511'd0, sel_out},  {511'd0, m_sel_out});
            check("A_out",    A_out, m_A);
            check("B_out",    B_out, m_B);
         end
         if (rst) begin
            m_valid = 1'b1; m_count = 0; m_pending = 1'b0; m_load = 1'b0;
            m_sel_out = 1'b0; m_A = '0; m_B = '0; m_last = -1; m_sel_asm = 1'b0;
         end else if (m_valid) begin
            bit nl;
            bit acc;
            nl  = m_pending && gap_clear(cyc, m_last) && !flush;
            acc = in_valid && !m_pending && !flush;
            if (nl) begin
               for (int k = 0; k < 16; k++) begin
                  m_A[k*DW +: DW] = pa[k];
                  m_B[k*DW +: DW] = pb[k];
               end
               m_sel_out = m_psel;
               m_last    = cyc + 1;
               m_pending = 1'b0;
            end
            if (flush) begin
               m_count   = 0;
               m_pending = 1'b0;
            end
            if (acc) begin
               ma[m_count] = a_elem;
               mb[m_count] = b_elem;
               if (m_count == 0) m_sel_asm = sel_in;
               if (m_count == 15) begin
                  pa = ma; pb = mb; m_psel = m_sel_asm;
                  m_pending = 1'b1;
                  m_count   = 0;
               end else begin
                  m_count++;
               end
            end
            m_load = nl;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic s, output int acc_cyc);
      bit done;
      done = 1'b0;
      acc_cyc = -1;
      in_valid = 1'b1; a_elem = a; b_elem = b; sel_in = s;
      for (int w = 0; w < 100 && !done; w++) begin
         @(negedge clk);
         if (in_ready) begin
            acc_cyc = cyc;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("beat_timeout", {511'd0, 1'b0}, {511'd0, 1'b1});
   endtask

   task automatic send_matrix(input logic [DW-1:0] abase, input logic [DW-1:0] bbase,
                              input logic s0, output int last_acc);
      int c;
      for (int k = 0; k < 16; k++) begin
         send_beat(abase + DW'(k), bbase + DW'(k), (k == 0) ? s0 : 1'b0, c);
      end
      last_acc = c;
   endtask

   task automatic wait_load(output int lc);
      bit got;
      got = 1'b0;
      lc  = -1;
      for (int w = 0; w < 200 && !got; w++) begin
         @(negedge clk);
         if (load_out) begin
            got = 1'b1;
            lc  = cyc;
         end
      end
      if (!got) check("load_timeout", {511'd0, 1'b0}, {511'd0, 1'b1});
      @(posedge clk); #1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int n, lc1, lc2, lc3;
      bit got;
      rst = 1'b1; in_valid = 1'b0; a_elem = '0; b_elem = '0; sel_in = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {511'd0, in_ready}, {511'd0, 1'b1});
      check("rst_busy",  {511'd0, busy},     {511'd0, 1'b0});
      check("rst_load",  {511'd0, load_out}, {511'd0, 1'b0});
      check("rst_A",     A_out, '0);
      check("rst_B",     B_out, '0);
      @(posedge clk); #1;

      // Fill and mode: sel_in=1 on beat 0 only.
      send_matrix(32'd1, 32'h100, 1'b1, n);
      @(negedge clk);
      check("mode_pre_sel", {511'd0, sel_out}, {511'd0, 1'b0});
      wait_load(lc1);
      check("fill_latency", BW'(lc1 - n), BW'(2));
      check("fill_A0",  {480'd0, A_out[31:0]},    {480'd0, 32'd1});
      check("fill_A15", {480'd0, A_out[511:480]}, {480'd0, 32'd16});
      check("fill_B4",  {480'd0, B_out[159:128]}, {480'd0, 32'h104});
      check("mode_sel", {511'd0, sel_out}, {511'd0, 1'b1});

      // Back-to-back second matrix is held off by the load gap.
      send_matrix(32'h200, 32'h300, 1'b0, n);
      got = 1'b0;
      lc2 = -1;
      for (int w = 0; w < 100 && !got; w++) begin
         @(negedge clk);
         if (load_out) begin
            got = 1'b1;
            lc2 = cyc;
         end else begin
            check("gap_ready_low", {511'd0, in_ready}, {511'd0, 1'b0});
            check("gap_hold_A",    {480'd0, A_out[31:0]}, {480'd0, 32'd1});
            check("gap_hold_sel",  {511'd0, sel_out}, {511'd0, 1'b1});
         end
      end
      if (!got) check("gap_timeout", {511'd0, 1'b0}, {511'd0, 1'b1});
      @(posedge clk); #1;
      check("gap_spacing", BW'(lc2 - lc1), BW'(GAP));
      check("gap_A0",  {480'd0, A_out[31:0]}, {480'd0, 32'h200});
      check("gap_sel", {511'd0, sel_out}, {511'd0, 1'b0});

      // Flush with beat 7 valid discards the partial matrix.
      got = 1'b0;
      for (int w = 0; w < 100 && !got; w++) begin
         @(negedge clk);
         if (!busy) got = 1'b1;
      end
      if (!got) check("idle_timeout", {511'd0, 1'b0}, {511'd0, 1'b1});
      @(posedge clk); #1;
      for (int k = 0; k < 7; k++) send_beat(32'h400 + DW'(k), 32'h500 + DW'(k), 1'b1, n);
      in_valid = 1'b1; flush = 1'b1; a_elem = 32'h407; b_elem = 32'h507;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      send_matrix(32'h300, 32'h600, 1'b0, n);
      wait_load(lc3);
      check("flush_latency", BW'(lc3 - n), BW'(2));
      check("flush_A0",  {480'd0, A_out[31:0]},    {480'd0, 32'h300});
      check("flush_A15", {480'd0, A_out[511:480]}, {480'd0, 32'h30F});
      check("flush_sel", {511'd0, sel_out}, {511'd0, 1'b0});

      // Reset five cycles after a load clears outputs and the gap.
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rgap_A",     A_out, '0);
      check("rgap_busy",  {511'd0, busy},     {511'd0, 1'b0});
      check("rgap_ready", {511'd0, in_ready}, {511'd0, 1'b1});
      @(posedge clk); #1;
      send_matrix(32'h700, 32'h800, 1'b1, n);
      wait_load(lc1);
      check("rgap_latency", BW'(lc1 - n), BW'(2));
      check("rgap_A0",      {480'd0, A_out[31:0]}, {480'd0, 32'h700});

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 399) == 0);
         flush    = ($urandom_range(0, 39) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         sel_in   = $urandom_range(0, 1);
         a_elem   = $urandom;
         b_elem   = $urandom;
         @(posedge clk); #1;
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
